// File: rtl/queue_wr_arbiter_if.sv
// Producer-side and Queue-side signals of the write arbiter, bundled with master/slave views.
// The slave view is the arbiter; the master view is the surrounding producers and Queue.
interface queue_wr_arbiter_if #(
  parameter int nreq  = 4,
  parameter int dbits = 128
);
  localparam int IW = $clog2(nreq);

  logic [nreq-1:0]       i_req_valid;
  logic [nreq-1:0]       i_req_last;
  logic [nreq*dbits-1:0] i_req_data;
  logic [nreq-1:0]       o_req_ready;
  logic                  i_q_full;
  logic                  o_q_we;
  logic [dbits-1:0]      o_q_wdata;
  logic [IW-1:0]         o_q_wsrc;
  logic                  o_busy;

  modport slave (
    input  i_req_valid, i_req_last, i_req_data, i_q_full,
    output o_req_ready, o_q_we, o_q_wdata, o_q_wsrc, o_busy
  );

  modport master (
    output i_req_valid, i_req_last, i_req_data, i_q_full,
    input  o_req_ready, o_q_we, o_q_wdata, o_q_wsrc, o_busy
  );
endinterface

// File: rtl/queue_wr_arbiter.sv
// Round-robin burst-locking arbiter sharing one Queue write port; accepted beat appears 1 cycle later.
// Backpressure: all readies drop while the Queue reports full; a held lock resumes with the same owner.
module queue_wr_arbiter #(
  parameter bit async_reset = 1'b1,
  parameter int nreq        = 4,
  parameter int dbits       = 128,
  parameter int max_burst   = 4
) (
  input logic               i_clk,
  input logic               i_nrst,
  queue_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(nreq);
  localparam int CW = $clog2(max_burst) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   beat_cnt;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW:0]     idx;
  logic [IW-1:0]   gnt;
  logic [nreq-1:0] ready;
  logic            accept;
  logic            gnt_last;
  logic [dbits-1:0] gnt_dat;
  logic            rdy_en;

  // Rotating priority search starting at rr_ptr; the index wraps explicitly for non-power-of-2 nreq.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < nreq; i++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(nreq))
        idx = idx - (IW+1)'(nreq);
      if (!win_vld && bus.i_req_valid[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[IW-1:0];
      end
    end
  end

  // Readies are forced low while reset is held so nothing is accepted during reset.
  assign rdy_en = (i_nrst || !async_reset) && !bus.i_q_full;

  always_comb begin
    ready = '0;
    gnt   = (state == LOCK) ? owner : win;
    if (rdy_en) begin
      if (state == IDLE) begin
        if (win_vld)
          ready[win] = 1'b1;
      end else if (bus.i_req_valid[owner]) begin
        ready[owner] = 1'b1;
      end
    end
  end

  assign accept          = |ready;
  assign gnt_last        = bus.i_req_last[gnt];
  assign gnt_dat         = bus.i_req_data[int'(gnt)*dbits +: dbits];
  assign bus.o_req_ready = ready;
  assign bus.o_busy      = (state == LOCK) || bus.o_q_we;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      beat_cnt      <= '0;
      bus.o_q_we    <= 1'b0;
      bus.o_q_wdata <= '0;
      bus.o_q_wsrc  <= '0;
    end else begin
      bus.o_q_we <= accept;
      if (accept) begin
        bus.o_q_wdata <= gnt_dat;
        bus.o_q_wsrc  <= gnt;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= (win == IW'(nreq-1)) ? '0 : win + IW'(1);
            if (!gnt_last && (max_burst > 1)) begin
              state    <= LOCK;
              owner    <= win;
              beat_cnt <= CW'(1);
            end
          end
        end
        LOCK: begin
          // Reaching max_burst forces a release even without last; remaining beats re-arbitrate.
          if (accept) begin
            if (gnt_last || (beat_cnt == CW'(max_burst-1))) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Directed bench for queue_wr_arbiter: readies checked each cycle, written beats checked via scoreboard.
module tb_queue_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DB    = 32;
  localparam int MB    = 4;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  queue_wr_arbiter_if #(.nreq(NREQ), .dbits(DB)) bus ();
  queue_wr_arbiter_if #(.nreq(3), .dbits(16)) bus3 ();

  queue_wr_arbiter #(.async_reset(1'b1), .nreq(NREQ), .dbits(DB), .max_burst(MB)) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  queue_wr_arbiter #(.async_reset(1'b1), .nreq(3), .dbits(16), .max_burst(2)) dut3 (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus3)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DB-1:0] dat;
  } exp_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] dat;
  } exp3_t;

  exp_t  sb[$];
  exp3_t sb3[$];
  int checks   = 0;
  int failures = 0;
  int seq      = 0;
  int occ      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bus.i_req_valid  = '0;
    bus.i_req_last   = '0;
    bus.i_req_data   = '0;
    bus.i_q_full     = 1'b0;
    bus3.i_req_valid = '0;
    bus3.i_req_last  = '0;
    bus3.i_req_data  = '0;
    bus3.i_q_full    = 1'b0;
    sb.delete();
    sb3.delete();
    occ = 0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  // Compares the write produced by the previous cycle's accept (if any) against the scoreboard.
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".we"}, bus.o_q_we, 1);
      chk({tag, ".src"}, bus.o_q_wsrc, e.src);
      chk({tag, ".dat"}, bus.o_q_wdata, e.dat);
    end else begin
      chk({tag, ".we0"}, bus.o_q_we, 0);
    end
    if (bus.o_q_we === 1'b1)
      occ++;
  endtask

  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic full, input logic [3:0] exp_rdy);
    exp_t e;
    seq++;
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_q_full    = full;
    for (int n = 0; n < NREQ; n++)
      bus.i_req_data[n*DB +: DB] = {8'(n), 24'(seq)};
    @(negedge clk);
    check_out(tag);
    chk({tag, ".rdy"}, bus.o_req_ready, exp_rdy);
    for (int n = 0; n < NREQ; n++) begin
      if (exp_rdy[n]) begin
        e.src = 2'(n);
        e.dat = {8'(n), 24'(seq)};
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input string tag, input logic [2:0] v, input logic [2:0] exp_rdy);
    exp3_t e;
    seq++;
    bus3.i_req_valid = v;
    bus3.i_req_last  = v;
    for (int n = 0; n < 3; n++)
      bus3.i_req_data[n*16 +: 16] = {8'(n), 8'(seq)};
    @(negedge clk);
    if (sb3.size() != 0) begin
      e = sb3.pop_front();
      chk({tag, ".we"}, bus3.o_q_we, 1);
      chk({tag, ".src"}, bus3.o_q_wsrc, e.src);
      chk({tag, ".dat"}, bus3.o_q_wdata, e.dat);
    end else begin
      chk({tag, ".we0"}, bus3.o_q_we, 0);
    end
    chk({tag, ".rdy"}, bus3.o_req_ready, exp_rdy);
    for (int n = 0; n < 3; n++) begin
      if (exp_rdy[n]) begin
        e.src = 2'(n);
        e.dat = {8'(n), 8'(seq)};
        sb3.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic f;
    // Reset state with every requester asking.
    bus.i_req_valid  = 4'hF;
    bus.i_req_last   = 4'hF;
    bus.i_req_data   = '0;
    bus.i_q_full     = 1'b0;
    bus3.i_req_valid = 3'h7;
    bus3.i_req_last  = 3'h7;
    bus3.i_req_data  = '0;
    bus3.i_q_full    = 1'b0;
    #12;
    chk("rst.rdy", bus.o_req_ready, 0);
    chk("rst.we", bus.o_q_we, 0);
    chk("rst.wdata", bus.o_q_wdata, 0);
    chk("rst.wsrc", bus.o_q_wsrc, 0);
    chk("rst.busy", bus.o_busy, 0);
    chk("rst.rdy3", bus3.o_req_ready, 0);

    // Three-beat burst from req0.
    do_reset();
    step("t1.a0", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    step("t1.a1", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    chk("t1.busy", bus.o_busy, 1);
    step("t1.a2", 4'b0001, 4'b0001, 1'b0, 4'b0001);
    step("t1.fl", 4'b0000, 4'b0000, 1'b0, 4'b0000);
    step("t1.idle", 4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("t1.busy0", bus.o_busy, 0);

    // All requesters valid with single-beat bursts: grants rotate 0,1,2,3,0,1.
    do_reset();
    for (int k = 0; k < 6; k++)
      step("t2.rr", 4'hF, 4'hF, 1'b0, 4'(1 << (k % 4)));
    step("t2.fl", 4'h0, 4'h0, 1'b0, 4'h0);

    // nreq=3: req2 grant wraps the pointer to 0, then 0 beats 1, then 1 beats 2.
    do_reset();
    step3("t3.r2", 3'b100, 3'b100);
    step3("t3.r0", 3'b011, 3'b001);
    step3("t3.r1", 3'b110, 3'b010);
    step3("t3.fl", 3'b000, 3'b000);

    // req1 unterminated 6-beat burst against req2: 4 beats, req2, then 2 more from req1.
    do_reset();
    for (int k = 0; k < 4; k++)
      step("t4.lock", 4'b0110, 4'b0100, 1'b0, 4'b0010);
    step("t4.r2", 4'b0110, 4'b0100, 1'b0, 4'b0100);
    step("t4.rest", 4'b0110, 4'b0100, 1'b0, 4'b0010);
    step("t4.rest", 4'b0110, 4'b0100, 1'b0, 4'b0010);
    step("t4.hold", 4'b0100, 4'b0100, 1'b0, 4'b0000);
    step("t4.hold", 4'b0100, 4'b0100, 1'b0, 4'b0000);

    // Full mid-burst of req0 with req3 waiting: lock holds, req0 resumes.
    do_reset();
    step("t5.a0", 4'b1001, 4'b1000, 1'b0, 4'b0001);
    step("t5.full", 4'b1001, 4'b1000, 1'b1, 4'b0000);
    step("t5.full", 4'b1001, 4'b1000, 1'b1, 4'b0000);
    chk("t5.busy", bus.o_busy, 1);
    step("t5.full", 4'b1001, 4'b1000, 1'b1, 4'b0000);
    step("t5.a1", 4'b1001, 4'b1000, 1'b0, 4'b0001);
    step("t5.a2", 4'b1001, 4'b1001, 1'b0, 4'b0001);
    step("t5.r3", 4'b1000, 4'b1000, 1'b0, 4'b1000);
    step("t5.fl", 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Queue fill with full derived from occupancy (no drain): never exceeds DEPTH.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      f = (occ >= DEPTH-1);
      step("fill", 4'b0010, 4'b0010, f, f ? 4'b0000 : 4'b0010);
      chk("fill.ovf", (occ <= DEPTH) ? 1 : 0, 1);
    end
    chk("fill.occ", occ, DEPTH);

    // Async reset while locked with a write in flight.
    do_reset();
    step("t6.a0", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    chk("t6.we_pre", bus.o_q_we, 1);
    bus.i_req_valid = 4'b0011;
    nrst = 1'b0;
    #1;
    chk("t6.rdy", bus.o_req_ready, 0);
    chk("t6.we", bus.o_q_we, 0);
    chk("t6.wdata", bus.o_q_wdata, 0);
    chk("t6.wsrc", bus.o_q_wsrc, 0);
    chk("t6.busy", bus.o_busy, 0);
    sb.delete();
    @(posedge clk);
    #1 nrst = 1'b1;
    step("t6.r0", 4'b0011, 4'b0011, 1'b0, 4'b0001);
    step("t6.r1", 4'b0010, 4'b0010, 1'b0, 4'b0010);
    step("t6.fl", 4'b0000, 4'b0000, 1'b0, 4'b0000);

    chk("sb.empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
